cdma_receiver: RTL and testbench

Despreading receiver paired with cdma_transmitter. It accepts 8-bit signed BPSK chip samples and regenerates the same 6-bit PN LFSR chip stream, masked by the selected user code. It correlates SF chips per data bit and outputs a hard bit decision, the raw correlation and a low-confidence flag. It sits after the channel/summing model, one instance per user.

---
 rtl/cdma_pkg.sv | 25 ++
 rtl/pn_lfsr.sv | 25 ++
 rtl/cdma_receiver.sv | 120 ++++++++++++
 tb/tb_cdma_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
// Shared constants, types and PN helpers for the CDMA transmitter/receiver pair.
// Both ends import this package so their chip sequences stay identical.
package cdma_pkg;

  localparam int unsigned PN_W = 6;
  localparam logic [PN_W-1:0] PN_SEED = 6'b000001;
  localparam int unsigned PN_TAP_A = 5;
  localparam int unsigned PN_TAP_B = 4;
  localparam int BPSK_AMP = 100;

  typedef enum logic {
    INTEGRATE,
    DECIDE
  } rx_state_e;

  // Fibonacci step {pn[4:0], pn[5]^pn[4]}, period 63.
  function automatic logic [PN_W-1:0] pn_next(input logic [PN_W-1:0] pn);
    return {pn[PN_W-2:0], pn[PN_TAP_A] ^ pn[PN_TAP_B]};
  endfunction

  function automatic logic pn_chip(input logic [PN_W-1:0] pn, input logic [PN_W-1:0] code);
    return ^(pn & code);
  endfunction

endpackage

// File: rtl/pn_lfsr.sv
// 6-bit PN generator shared by the transmitter and the receiver.
// Load restarts at the seed; advance steps once per accepted chip.
module pn_lfsr
  import cdma_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_advance,
  output logic [PN_W-1:0] o_pn
);

  logic [PN_W-1:0] r_pn;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_pn <= PN_SEED;
    end else if (i_advance) begin
      r_pn <= pn_next(r_pn);
    end
  end

  assign o_pn = r_pn;

endmodule

// File: rtl/cdma_receiver.sv
// Despreading receiver: correlates SF chips against the selected user's PN mask
// and emits a hard decision, the raw correlation and a low-confidence flag.
module cdma_receiver
  import cdma_pkg::*;
#(
  parameter int unsigned SF          = 8,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned CONF_THRESH = 200
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sync,
  input  logic signed [7:0]       i_sample_in,
  input  logic                    i_sample_valid,
  input  logic [PN_W-1:0]         i_user_code_1,
  input  logic [PN_W-1:0]         i_user_code_2,
  input  logic                    i_user_select,
  output logic                    o_data_out,
  output logic                    o_data_valid,
  output logic signed [ACC_W-1:0] o_corr_out,
  output logic                    o_low_conf,
  output logic                    o_busy
);

  localparam int unsigned CNT_W = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(SF - 1);

  logic                    w_accept;
  logic                    w_chip;
  logic [PN_W-1:0]         w_pn;
  logic [PN_W-1:0]         w_code;
  logic signed [ACC_W-1:0] w_sample_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;
  logic [ACC_W:0]          w_final_abs;
  logic                    w_final_pos;

  rx_state_e               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_final;
  logic                    r_data_out;
  logic                    r_data_valid;
  logic signed [ACC_W-1:0] r_corr_out;
  logic                    r_low_conf;
  logic                    r_busy;

  // sync outranks sample_valid: the coincident sample is discarded.
  assign w_accept = i_sample_valid & ~i_sync;

  pn_lfsr u_lfsr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_sync),
    .i_advance (w_accept),
    .o_pn      (w_pn)
  );

  assign w_code       = i_user_select ? i_user_code_2 : i_user_code_1;
  assign w_chip       = pn_chip(w_pn, w_code);
  assign w_sample_ext = ACC_W'(i_sample_in);
  // Negation happens at ACC_W width so -(-128) stays positive.
  assign w_term       = w_chip ? -w_sample_ext : w_sample_ext;
  assign w_sum        = r_acc + w_term;

  // One extra bit keeps |most-negative| representable.
  assign w_final_abs  = r_final[ACC_W-1] ? -{r_final[ACC_W-1], r_final}
                                         : {r_final[ACC_W-1], r_final};
  assign w_final_pos  = !r_final[ACC_W-1] && (r_final != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= INTEGRATE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_final      <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_corr_out   <= '0;
      r_low_conf   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;

      if (r_state == DECIDE) begin
        r_corr_out   <= r_final;
        r_data_out   <= w_final_pos;
        r_low_conf   <= (w_final_abs < (ACC_W + 1)'(CONF_THRESH));
        r_data_valid <= 1'b1;
        r_state      <= INTEGRATE;
      end

      // The integrator keeps running during DECIDE so no chip is dropped.
      if (i_sync) begin
        r_cnt  <= '0;
        r_acc  <= '0;
        r_busy <= 1'b0;
      end else if (i_sample_valid) begin
        if (r_cnt == LAST_CHIP) begin
          r_final <= w_sum;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_busy  <= 1'b0;
          r_state <= DECIDE;
        end else begin
          r_acc  <= w_sum;
          r_cnt  <= r_cnt + 1'b1;
          r_busy <= 1'b1;
        end
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_corr_out   = r_corr_out;
  assign o_low_conf   = r_low_conf;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_cdma_receiver.sv
// Directed bench for cdma_receiver: TX loopback, gaps, corruption, two-user sum,
// sync and reset mid-bit, with hand-computed expected decisions.
module tb_cdma_receiver;
  import cdma_pkg::*;

  localparam int unsigned SF = 8;
  localparam logic [5:0] CODE1 = 6'b101101;
  localparam logic [5:0] CODE2 = 6'b010011;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sync = 1'b0;
  logic signed [7:0]  sample_in = '0;
  logic               sample_valid = 1'b0;
  logic [5:0]         code1 = CODE1;
  logic [5:0]         code2 = CODE2;
  logic               user_select = 1'b0;
  logic               data_out;
  logic               data_valid;
  logic signed [15:0] corr_out;
  logic               low_conf;
  logic               busy;

  cdma_receiver #(
    .SF          (SF),
    .ACC_W       (16),
    .CONF_THRESH (200)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sync         (sync),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .i_user_code_1  (code1),
    .i_user_code_2  (code2),
    .i_user_select  (user_select),
    .o_data_out     (data_out),
    .o_data_valid   (data_valid),
    .o_corr_out     (corr_out),
    .o_low_conf     (low_conf),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] tx_pn = PN_SEED;

  logic               q_data[$];
  logic signed [15:0] q_corr[$];
  logic               q_lc[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Collect decisions and check that each lands one edge after its SF-th accepted chip.
  int edge_n = 0;
  int last_end = -100;
  int chips = 0;
  always @(posedge clk) begin
    edge_n++;
    if (rst || sync) begin
      chips = 0;
    end else if (sample_valid) begin
      chips++;
      if (chips == SF) begin
        chips = 0;
        last_end = edge_n;
      end
    end
    #1;
    if (data_valid) begin
      check("dv_latency", edge_n, last_end + 1);
      q_data.push_back(data_out);
      q_corr.push_back(corr_out);
      q_lc.push_back(low_conf);
    end
  end

  task automatic drive(input logic v, input logic signed [7:0] s, input logic sy, input logic r);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    sync         = sy;
    rst          = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'sd0, 1'b0, 1'b0);
  endtask

  task automatic do_sync();
    drive(1'b0, 8'sd0, 1'b1, 1'b0);
    tx_pn = PN_SEED;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_corr.delete();
    q_lc.delete();
  endtask

  function automatic logic signed [7:0] tx_sample(input logic d, input logic [5:0] code,
                                                  input logic [5:0] pn);
    return (d ^ pn_chip(pn, code)) ? 8'(BPSK_AMP) : -8'(BPSK_AMP);
  endfunction

  // n chips of user-1 data d; neg[k] flips chip k; gap inserts an idle cycle after each chip.
  task automatic send_chips(input logic d, input int n, input logic [7:0] neg, input logic gap);
    logic signed [7:0] s;
    for (int k = 0; k < n; k++) begin
      s = tx_sample(d, CODE1, tx_pn);
      if (neg[k]) s = -s;
      tx_pn = pn_next(tx_pn);
      drive(1'b1, s, 1'b0, 1'b0);
      if (gap) drive(1'b0, 8'sd77, 1'b0, 1'b0);
    end
  endtask

  task automatic check_dec(input string tag, input int idx, input logic d, input int c,
                           input logic lc);
    if (idx < q_data.size()) begin
      check({tag, "_data"}, q_data[idx], d);
      check({tag, "_corr"}, q_corr[idx], c);
      check({tag, "_lowconf"}, q_lc[idx], lc);
    end
  endtask

  logic [7:0] bits_u1 = 8'b1001_0110;
  logic [7:0] bits_u2 = 8'b0100_1011;

  initial begin
    // 1: reset and idle
    repeat (3) drive(1'b0, 8'sd0, 1'b0, 1'b1);
    idle(1);
    check("rst_pn", dut.w_pn, 6'b000001);
    check("rst_dv", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_corr", corr_out, 0);
    check("rst_lowconf", low_conf, 0);
    check("rst_busy", busy, 0);
    idle(5);
    check("idle_no_dv", q_data.size(), 0);

    // 2: continuous loopback, bits 1,0,1,1
    clear_q();
    do_sync();
    send_chips(1'b1, SF, 8'h00, 1'b0);
    send_chips(1'b0, SF, 8'h00, 1'b0);
    send_chips(1'b1, SF, 8'h00, 1'b0);
    send_chips(1'b1, SF, 8'h00, 1'b0);
    idle(3);
    check("loop_count", q_data.size(), 4);
    check_dec("loop0", 0, 1'b1, 800, 1'b0);
    check_dec("loop1", 1, 1'b0, -800, 1'b0);
    check_dec("loop2", 2, 1'b1, 800, 1'b0);
    check_dec("loop3", 3, 1'b1, 800, 1'b0);

    // 3: gapped input
    clear_q();
    do_sync();
    send_chips(1'b1, SF, 8'h00, 1'b1);
    send_chips(1'b0, SF, 8'h00, 1'b1);
    send_chips(1'b1, SF, 8'h00, 1'b1);
    send_chips(1'b1, SF, 8'h00, 1'b1);
    idle(3);
    check("gap_count", q_data.size(), 4);
    check_dec("gap0", 0, 1'b1, 800, 1'b0);
    check_dec("gap1", 1, 1'b0, -800, 1'b0);
    check_dec("gap2", 2, 1'b1, 800, 1'b0);
    check_dec("gap3", 3, 1'b1, 800, 1'b0);

    // 4: corruption, threshold edge, zeros, -128 sample
    clear_q();
    do_sync();
    send_chips(1'b1, SF, 8'b0000_0100, 1'b0);
    send_chips(1'b1, SF, 8'b0010_0101, 1'b0);
    send_chips(1'b0, SF, 8'b0001_0011, 1'b0);
    repeat (SF) drive(1'b1, 8'sd0, 1'b0, 1'b0);
    do_sync();
    // code1[0]=1 so chip 0 after sync is inverted: -(-128) = +128
    drive(1'b1, 8'sh80, 1'b0, 1'b0);
    repeat (SF - 1) drive(1'b1, 8'sd0, 1'b0, 1'b0);
    idle(3);
    check("corr_count", q_data.size(), 5);
    check_dec("neg1", 0, 1'b1, 600, 1'b0);
    check_dec("neg3", 1, 1'b1, 200, 1'b0);
    check_dec("neg3d0", 2, 1'b0, -200, 1'b0);
    check_dec("zeros", 3, 1'b0, 0, 1'b1);
    check_dec("min_sample", 4, 1'b1, 128, 1'b1);
    check("hold_corr", corr_out, 128);
    check("hold_dv", data_valid, 0);

    // 5: two-user sum, decode user 2
    clear_q();
    user_select = 1'b1;
    do_sync();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < SF; k++) begin
        int sum;
        sum = int'(tx_sample(bits_u1[b], CODE1, tx_pn)) + int'(tx_sample(bits_u2[b], CODE2, tx_pn));
        if (sum > 127) sum = 127;
        if (sum < -128) sum = -128;
        tx_pn = pn_next(tx_pn);
        drive(1'b1, 8'(sum), 1'b0, 1'b0);
      end
    end
    idle(3);
    user_select = 1'b0;
    check("mu_count", q_data.size(), 8);
    for (int b = 0; b < 8 && b < q_data.size(); b++) begin
      check($sformatf("mu_bit%0d", b), q_data[b], bits_u2[b]);
    end

    // 6: sync mid-bit, then rst mid-bit
    clear_q();
    do_sync();
    send_chips(1'b1, 3, 8'h00, 1'b0);
    drive(1'b1, 8'sd100, 1'b1, 1'b0);
    check("mid_busy", busy, 1);
    idle(1);
    check("sync_pn", dut.w_pn, 6'b000001);
    check("sync_busy", busy, 0);
    tx_pn = PN_SEED;
    send_chips(1'b0, SF, 8'h00, 1'b0);
    send_chips(1'b1, 5, 8'h00, 1'b0);
    drive(1'b1, 8'sd100, 1'b0, 1'b1);
    idle(5);
    check("sync_rst_count", q_data.size(), 1);
    check_dec("after_sync", 0, 1'b0, -800, 1'b0);
    check("rst_mid_corr", corr_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pn", dut.w_pn, 6'b000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
